// File: rtl/exc_commit_unit_if.sv
// Bundle of pipeline-side lane signals and CP0/fetch-side results for exc_commit_unit.
// The master modport is the pipeline/bench side, and the slave modport is the commit unit.
interface exc_commit_unit_if #(
    parameter int LANES  = 2,
    parameter int ADDR_W = 32
);
    logic [LANES-1:0]        lane_valid;
    logic [14*LANES-1:0]     lane_exc;
    logic [ADDR_W*LANES-1:0] lane_pc;
    logic [ADDR_W*LANES-1:0] lane_mem_addr;
    logic [LANES-1:0]        lane_is_store;
    logic [LANES-1:0]        lane_is_branch;
    logic                    lane0_in_ds;
    logic                    status_exl;
    logic                    int_req;
    logic [ADDR_W-1:0]       cp0_epc_in;
    logic                    redirect_ready;

    logic [LANES-1:0]        commit_mask;
    logic                    redirect_valid;
    logic [ADDR_W-1:0]       redirect_pc;
    logic                    flush;
    logic                    cp0_wen;
    logic [ADDR_W-1:0]       cp0_epc;
    logic                    cp0_bd;
    logic [4:0]              cp0_exccode;
    logic                    cp0_badvaddr_wen;
    logic [ADDR_W-1:0]       cp0_badvaddr;
    logic                    cp0_exl_clear;
    logic                    busy;

    modport master (
        output lane_valid, lane_exc, lane_pc, lane_mem_addr, lane_is_store,
               lane_is_branch, lane0_in_ds, status_exl, int_req, cp0_epc_in,
               redirect_ready,
        input  commit_mask, redirect_valid, redirect_pc, flush, cp0_wen, cp0_epc,
               cp0_bd, cp0_exccode, cp0_badvaddr_wen, cp0_badvaddr, cp0_exl_clear,
               busy
    );

    modport slave (
        input  lane_valid, lane_exc, lane_pc, lane_mem_addr, lane_is_store,
               lane_is_branch, lane0_in_ds, status_exl, int_req, cp0_epc_in,
               redirect_ready,
        output commit_mask, redirect_valid, redirect_pc, flush, cp0_wen, cp0_epc,
               cp0_bd, cp0_exccode, cp0_badvaddr_wen, cp0_badvaddr, cp0_exl_clear,
               busy
    );
endinterface

// File: rtl/exc_commit_unit.sv
// Precise-exception/commit arbiter: picks the oldest excepting lane, registers the CP0 update, and redirects fetch.
// Optional macro EXC_INT_SYNC_EN: when defined, int_req passes through a two-flop synchroniser before use.
module exc_commit_unit #(
    parameter int                LANES        = 2,
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int                DRAIN_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    exc_commit_unit_if.slave   bus
);
    localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;

    state_t                      r_state;
    state_t                      w_nextState;
    logic [CNT_W-1:0]            r_cnt;

    logic                        r_redirectValid;
    logic [ADDR_W-1:0]           r_redirectPc;
    logic                        r_flush;
    logic                        r_cp0Wen;
    logic [ADDR_W-1:0]           r_epc;
    logic                        r_bd;
    logic [4:0]                  r_exccode;
    logic                        r_badvWen;
    logic [ADDR_W-1:0]           r_badv;
    logic                        r_exlClear;

    logic                        w_intReq;
    logic [LANES:0]              w_prevBr;
    logic [ADDR_W*(LANES+1)-1:0] w_prevPc;
    logic [LANES-1:0]            w_excLane;
    logic [LANES-1:0]            w_mask;
    logic                        w_found;
    logic                        w_isEret;
    logic [4:0]                  w_code;
    logic                        w_badvWen;
    logic [ADDR_W-1:0]           w_badv;
    logic [ADDR_W-1:0]           w_epc;
    logic                        w_bd;
    logic [13:0]                 w_flags;
    logic                        w_takeInt;
    logic                        w_blocked;
    logic                        w_unused;

`ifdef EXC_INT_SYNC_EN
    logic r_intMeta;
    logic r_intSync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_intMeta <= 1'b0;
            r_intSync <= 1'b0;
        end else begin
            r_intMeta <= bus.int_req;
            r_intSync <= r_intMeta;
        end
    end

    assign w_intReq = r_intSync;
`else
    assign w_intReq = bus.int_req;
`endif

    // Slot i holds lane i's predecessor: lane 0's predecessor is the delay-slot branch at pc-4.
    assign w_prevBr = {bus.lane_is_branch, bus.lane0_in_ds};
    assign w_prevPc = {bus.lane_pc, bus.lane_pc[ADDR_W-1:0] - ADDR_W'(4)};
    assign w_unused = ^{bus.lane_exc, w_prevBr[LANES], w_prevPc[ADDR_W*LANES +: ADDR_W]};

    // Descending scan so the lowest-index (oldest) excepting lane is the one left selected.
    always_comb begin
        w_found   = 1'b0;
        w_isEret  = 1'b0;
        w_code    = 5'd0;
        w_badvWen = 1'b0;
        w_badv    = '0;
        w_epc     = '0;
        w_bd      = 1'b0;
        w_excLane = '0;
        w_flags   = '0;
        w_takeInt = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            w_flags   = bus.lane_exc[14*i +: 14];
            w_takeInt = (i == 0) && w_intReq && !bus.status_exl;
            if (bus.lane_valid[i] && (w_takeInt || (|w_flags[7:1]))) begin
                w_excLane[i] = 1'b1;
                w_found      = 1'b1;
                w_bd         = w_prevBr[i];
                w_epc        = w_prevBr[i] ? w_prevPc[ADDR_W*i +: ADDR_W]
                                           : bus.lane_pc[ADDR_W*i +: ADDR_W];
                w_isEret     = 1'b0;
                w_badvWen    = 1'b0;
                w_badv       = '0;
                if (w_takeInt) begin
                    w_code = 5'd0;
                end else if (w_flags[6]) begin
                    w_code    = 5'd4;
                    w_badvWen = 1'b1;
                    w_badv    = bus.lane_pc[ADDR_W*i +: ADDR_W];
                end else if (w_flags[2]) begin
                    w_code = 5'h0a;
                end else if (w_flags[1]) begin
                    w_code = 5'h0c;
                end else if (w_flags[3]) begin
                    w_code = 5'd8;
                end else if (w_flags[4]) begin
                    w_code = 5'd9;
                end else if (w_flags[5]) begin
                    w_isEret = 1'b1;
                    w_code   = 5'd0;
                end else begin
                    w_code    = bus.lane_is_store[i] ? 5'd5 : 5'd4;
                    w_badvWen = 1'b1;
                    w_badv    = bus.lane_mem_addr[ADDR_W*i +: ADDR_W];
                end
            end
        end
    end

    always_comb begin
        w_mask    = '0;
        w_blocked = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (w_excLane[i]) begin
                w_blocked = 1'b1;
            end
            w_mask[i] = bus.lane_valid[i] && !w_blocked;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:     if (w_found)              w_nextState = REDIRECT;
            REDIRECT: if (bus.redirect_ready)   w_nextState = DRAIN;
            DRAIN:    if (r_cnt == CNT_W'(1))   w_nextState = IDLE;
            default:                            w_nextState = IDLE;
        endcase
    end

    // Strobes default low every cycle so each one lasts exactly the cycle after the exception is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt           <= '0;
            r_redirectValid <= 1'b0;
            r_redirectPc    <= '0;
            r_flush         <= 1'b0;
            r_cp0Wen        <= 1'b0;
            r_epc           <= '0;
            r_bd            <= 1'b0;
            r_exccode       <= 5'd0;
            r_badvWen       <= 1'b0;
            r_badv          <= '0;
            r_exlClear      <= 1'b0;
        end else begin
            r_flush    <= 1'b0;
            r_cp0Wen   <= 1'b0;
            r_badvWen  <= 1'b0;
            r_exlClear <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_flush         <= 1'b1;
                        r_redirectValid <= 1'b1;
                        if (w_isEret) begin
                            r_redirectPc <= bus.cp0_epc_in;
                            r_exlClear   <= 1'b1;
                        end else begin
                            r_redirectPc <= EXC_VECTOR;
                            r_cp0Wen     <= 1'b1;
                            r_epc        <= w_epc;
                            r_bd         <= w_bd;
                            r_exccode    <= w_code;
                            if (w_badvWen) begin
                                r_badvWen <= 1'b1;
                                r_badv    <= w_badv;
                            end
                        end
                    end
                end
                REDIRECT: begin
                    if (bus.redirect_ready) begin
                        r_redirectValid <= 1'b0;
                        r_cnt           <= CNT_W'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.commit_mask      = (r_state == IDLE) ? w_mask : '0;
    assign bus.redirect_valid   = r_redirectValid;
    assign bus.redirect_pc      = r_redirectPc;
    assign bus.flush            = r_flush;
    assign bus.cp0_wen          = r_cp0Wen;
    assign bus.cp0_epc          = r_epc;
    assign bus.cp0_bd           = r_bd;
    assign bus.cp0_exccode      = r_exccode;
    assign bus.cp0_badvaddr_wen = r_badvWen;
    assign bus.cp0_badvaddr     = r_badv;
    assign bus.cp0_exl_clear    = r_exlClear;
    assign bus.busy             = (r_state != IDLE);
endmodule

// File: tb/tb_exc_commit_unit.sv
// Directed self-checking bench for exc_commit_unit (LANES=2, ADDR_W=32, DRAIN_CYCLES=2).
// Inputs change #1 after a rising edge; both registered and combinational outputs are sampled before the next edge.
module tb_exc_commit_unit;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    exc_commit_unit_if #(.LANES(2), .ADDR_W(32)) bus ();

    exc_commit_unit #(
        .LANES(2), .ADDR_W(32), .EXC_VECTOR(32'hBFC00380), .DRAIN_CYCLES(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clearInputs();
        bus.lane_valid     = 2'b00;
        bus.lane_exc       = '0;
        bus.lane_pc        = '0;
        bus.lane_mem_addr  = '0;
        bus.lane_is_store  = 2'b00;
        bus.lane_is_branch = 2'b00;
        bus.lane0_in_ds    = 1'b0;
        bus.status_exl     = 1'b0;
        bus.int_req        = 1'b0;
        bus.cp0_epc_in     = '0;
        bus.redirect_ready = 1'b1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the unit to return to IDLE; an expired bound counts as a failure.
    task automatic waitIdle(input string name);
        for (int k = 0; k < 20 && bus.busy; k++) stepCycle();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%0b required 0", name, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clearInputs();
        repeat (2) stepCycle();
        checks++;
        if ({bus.redirect_valid, bus.flush, bus.cp0_wen, bus.cp0_exl_clear,
             bus.cp0_badvaddr_wen, bus.busy, bus.commit_mask} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0", {bus.redirect_valid, bus.flush, bus.cp0_wen,
                     bus.cp0_exl_clear, bus.cp0_badvaddr_wen, bus.busy, bus.commit_mask});
        end
        checks++;
        if ({bus.redirect_pc, bus.cp0_epc, bus.cp0_badvaddr} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: pc=%h epc=%h badv=%h required 0",
                     bus.redirect_pc, bus.cp0_epc, bus.cp0_badvaddr);
        end
        rst_n = 1'b1;
        stepCycle();
    endtask

    task automatic test_ov_lane1();
        clearInputs();
        bus.lane_valid = 2'b11;
        bus.lane_pc    = {32'h80001004, 32'h80001000};
        bus.lane_exc   = {14'h0002, 14'h0000};
        #1;
        checks++;
        if (bus.commit_mask !== 2'b01) begin
            errors++;
            $display("FAIL ov_mask: got %b required 01", bus.commit_mask);
        end
        stepCycle();
        checks++;
        if (bus.cp0_exccode !== 5'h0c || bus.cp0_epc !== 32'h80001004 || bus.cp0_bd !== 1'b0) begin
            errors++;
            $display("FAIL ov_cp0: code=%h epc=%h bd=%b required 0c 80001004 0",
                     bus.cp0_exccode, bus.cp0_epc, bus.cp0_bd);
        end
        checks++;
        if (bus.redirect_pc !== 32'hBFC00380 || bus.redirect_valid !== 1'b1 || bus.flush !== 1'b1 ||
            bus.cp0_wen !== 1'b1 || bus.cp0_badvaddr_wen !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL ov_redirect: pc=%h v=%b fl=%b wen=%b bwen=%b busy=%b required bfc00380 1 1 1 0 1",
                     bus.redirect_pc, bus.redirect_valid, bus.flush, bus.cp0_wen,
                     bus.cp0_badvaddr_wen, bus.busy);
        end
        clearInputs();
        stepCycle();
        checks++;
        if (bus.flush !== 1'b0 || bus.cp0_wen !== 1'b0 || bus.redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL ov_pulse: fl=%b wen=%b v=%b required 0 0 0",
                     bus.flush, bus.cp0_wen, bus.redirect_valid);
        end
        waitIdle("ov");
    endtask

    task automatic test_adel_bd();
        clearInputs();
        bus.lane_valid     = 2'b11;
        bus.lane_pc        = {32'h80002004, 32'h80002000};
        bus.lane_is_branch = 2'b01;
        bus.lane_exc       = {14'h0040, 14'h0000};
        stepCycle();
        checks++;
        if (bus.cp0_exccode !== 5'd4 || bus.cp0_epc !== 32'h80002000 || bus.cp0_bd !== 1'b1 ||
            bus.cp0_badvaddr !== 32'h80002004 || bus.cp0_badvaddr_wen !== 1'b1) begin
            errors++;
            $display("FAIL adel_bd: code=%h epc=%h bd=%b badv=%h bwen=%b required 04 80002000 1 80002004 1",
                     bus.cp0_exccode, bus.cp0_epc, bus.cp0_bd, bus.cp0_badvaddr, bus.cp0_badvaddr_wen);
        end
        clearInputs();
        waitIdle("adel");
    endtask

    task automatic test_ade_store();
        clearInputs();
        bus.lane_valid    = 2'b11;
        bus.lane_pc       = {32'h80003004, 32'h80003000};
        bus.lane_mem_addr = {32'h0, 32'h00000003};
        bus.lane_is_store = 2'b01;
        bus.lane_exc      = {14'h0004, 14'h0080};
        #1;
        checks++;
        if (bus.commit_mask !== 2'b00) begin
            errors++;
            $display("FAIL ade_mask: got %b required 00", bus.commit_mask);
        end
        stepCycle();
        checks++;
        if (bus.cp0_exccode !== 5'd5 || bus.cp0_badvaddr !== 32'h3 || bus.cp0_epc !== 32'h80003000 ||
            bus.cp0_bd !== 1'b0) begin
            errors++;
            $display("FAIL ade_cp0: code=%h badv=%h epc=%h bd=%b required 05 00000003 80003000 0",
                     bus.cp0_exccode, bus.cp0_badvaddr, bus.cp0_epc, bus.cp0_bd);
        end
        clearInputs();
        waitIdle("ade");
    endtask

    task automatic test_priority_and_ds();
        clearInputs();
        bus.lane_valid = 2'b11;
        bus.lane_pc    = {32'h80004004, 32'h80004000};
        bus.lane_exc   = {14'h0006, 14'h0000};
        stepCycle();
        checks++;
        if (bus.cp0_exccode !== 5'h0a) begin
            errors++;
            $display("FAIL prio_ri_ov: code=%h required 0a", bus.cp0_exccode);
        end
        clearInputs();
        waitIdle("prio");
        bus.lane_valid  = 2'b01;
        bus.lane0_in_ds = 1'b1;
        bus.lane_pc     = 64'h0;
        bus.lane_exc    = {14'h0000, 14'h0010};
        stepCycle();
        checks++;
        if (bus.cp0_exccode !== 5'd9 || bus.cp0_epc !== 32'hFFFFFFFC || bus.cp0_bd !== 1'b1) begin
            errors++;
            $display("FAIL ds_wrap: code=%h epc=%h bd=%b required 09 fffffffc 1",
                     bus.cp0_exccode, bus.cp0_epc, bus.cp0_bd);
        end
        clearInputs();
        waitIdle("ds");
    endtask

    task automatic test_eret_stall();
        int exlPulses;
        exlPulses = 0;
        clearInputs();
        bus.lane_valid = 2'b11;
        bus.lane_pc    = {32'h80005004, 32'h80005000};
        bus.cp0_epc_in = 32'h80000100;
        bus.lane_exc   = {14'h0000, 14'h0020};
        #1;
        checks++;
        if (bus.commit_mask !== 2'b00) begin
            errors++;
            $display("FAIL eret_mask: got %b required 00", bus.commit_mask);
        end
        stepCycle();
        checks++;
        if (bus.redirect_pc !== 32'h80000100 || bus.cp0_wen !== 1'b0 || bus.flush !== 1'b1) begin
            errors++;
            $display("FAIL eret_target: pc=%h wen=%b fl=%b required 80000100 0 1",
                     bus.redirect_pc, bus.cp0_wen, bus.flush);
        end
        clearInputs();
        bus.redirect_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (bus.cp0_exl_clear === 1'b1) exlPulses++;
            checks++;
            if (bus.redirect_valid !== 1'b1 || bus.busy !== 1'b1 || bus.redirect_pc !== 32'h80000100) begin
                errors++;
                $display("FAIL eret_hold%0d: v=%b busy=%b pc=%h required 1 1 80000100",
                         k, bus.redirect_valid, bus.busy, bus.redirect_pc);
            end
            if (k == 3) bus.redirect_ready = 1'b1;
            stepCycle();
        end
        checks++;
        if (exlPulses != 1) begin
            errors++;
            $display("FAIL eret_exl_pulses: got %0d required 1", exlPulses);
        end
        checks++;
        if (bus.redirect_valid !== 1'b0 || bus.busy !== 1'b1 || bus.commit_mask !== 2'b00) begin
            errors++;
            $display("FAIL eret_drain1: v=%b busy=%b mask=%b required 0 1 00",
                     bus.redirect_valid, bus.busy, bus.commit_mask);
        end
        bus.lane_valid = 2'b11;
        stepCycle();
        checks++;
        if (bus.busy !== 1'b1 || bus.commit_mask !== 2'b00) begin
            errors++;
            $display("FAIL eret_drain2: busy=%b mask=%b required 1 00", bus.busy, bus.commit_mask);
        end
        stepCycle();
        checks++;
        if (bus.busy !== 1'b0 || bus.commit_mask !== 2'b11) begin
            errors++;
            $display("FAIL eret_idle: busy=%b mask=%b required 0 11", bus.busy, bus.commit_mask);
        end
        clearInputs();
    endtask

    task automatic test_interrupt();
        clearInputs();
        bus.int_req = 1'b1;
        repeat (3) stepCycle();
        bus.lane_valid = 2'b01;
        bus.lane_pc    = {32'h0, 32'h80006000};
        bus.lane_exc   = {14'h0000, 14'h0008};
        stepCycle();
        checks++;
        if (bus.cp0_exccode !== 5'd0 || bus.cp0_wen !== 1'b1 || bus.cp0_epc !== 32'h80006000) begin
            errors++;
            $display("FAIL int_taken: code=%h wen=%b epc=%h required 00 1 80006000",
                     bus.cp0_exccode, bus.cp0_wen, bus.cp0_epc);
        end
        bus.lane_valid = 2'b00;
        waitIdle("int");
        bus.status_exl = 1'b1;
        bus.lane_valid = 2'b01;
        stepCycle();
        checks++;
        if (bus.cp0_exccode !== 5'd8 || bus.cp0_wen !== 1'b1) begin
            errors++;
            $display("FAIL int_masked_exl: code=%h wen=%b required 08 1", bus.cp0_exccode, bus.cp0_wen);
        end
        clearInputs();
        waitIdle("int_exl");
    endtask

    task automatic test_back_to_back();
        clearInputs();
        bus.lane_valid     = 2'b11;
        bus.lane_pc        = {32'h80007004, 32'h80007000};
        bus.lane_exc       = {14'h0002, 14'h0000};
        bus.redirect_ready = 1'b0;
        stepCycle();
        bus.lane_exc = {14'h0000, 14'h0004};
        #1;
        checks++;
        if (bus.commit_mask !== 2'b00) begin
            errors++;
            $display("FAIL b2b_busy_mask: got %b required 00", bus.commit_mask);
        end
        stepCycle();
        checks++;
        if (bus.flush !== 1'b0 || bus.cp0_exccode !== 5'h0c || bus.redirect_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ignored: fl=%b code=%h v=%b required 0 0c 1",
                     bus.flush, bus.cp0_exccode, bus.redirect_valid);
        end
        bus.lane_valid     = 2'b00;
        bus.redirect_ready = 1'b1;
        waitIdle("b2b");
        bus.lane_valid = 2'b11;
        stepCycle();
        checks++;
        if (bus.cp0_exccode !== 5'h0a || bus.cp0_epc !== 32'h80007000 || bus.flush !== 1'b1) begin
            errors++;
            $display("FAIL b2b_next: code=%h epc=%h fl=%b required 0a 80007000 1",
                     bus.cp0_exccode, bus.cp0_epc, bus.flush);
        end
        clearInputs();
        waitIdle("b2b_next");
    endtask

    task automatic test_reset_mid_redirect();
        clearInputs();
        bus.lane_valid     = 2'b11;
        bus.lane_pc        = {32'h80008004, 32'h80008000};
        bus.lane_exc       = {14'h0000, 14'h0008};
        bus.redirect_ready = 1'b0;
        stepCycle();
        bus.lane_valid = 2'b00;
        stepCycle();
        checks++;
        if (bus.redirect_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: v=%b required 1", bus.redirect_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.redirect_valid, bus.flush, bus.cp0_wen, bus.cp0_exl_clear, bus.busy} !== 5'b0 ||
            bus.redirect_pc !== 32'h0 || bus.cp0_epc !== 32'h0 || bus.cp0_exccode !== 5'd0) begin
            errors++;
            $display("FAIL rst_mid: v=%b busy=%b pc=%h epc=%h code=%h required 0 0 0 0 0",
                     bus.redirect_valid, bus.busy, bus.redirect_pc, bus.cp0_epc, bus.cp0_exccode);
        end
        stepCycle();
        rst_n = 1'b1;
        clearInputs();
        bus.lane_valid = 2'b11;
        bus.lane_pc    = {32'h80009004, 32'h80009000};
        #1;
        checks++;
        if (bus.commit_mask !== 2'b11) begin
            errors++;
            $display("FAIL rst_clean_mask: got %b required 11", bus.commit_mask);
        end
        stepCycle();
        checks++;
        if (bus.flush !== 1'b0 || bus.busy !== 1'b0 || bus.redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_reissue: fl=%b busy=%b v=%b required 0 0 0",
                     bus.flush, bus.busy, bus.redirect_valid);
        end
        clearInputs();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_ov_lane1();
        test_adel_bd();
        test_ade_store();
        test_priority_and_ds();
        test_eret_stall();
        test_interrupt();
        test_back_to_back();
        test_reset_mid_redirect();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
